// File: rtl/ball_motion_sched.sv
// ball_motion_sched: per-frame position/bounce sequencer for the bouncing-ball sprite.
// A frame_tick in IDLE starts a three-cycle update: CALC_X, CALC_Y, then COMMIT.
// Positions change only at COMMIT, so the renderer sees them stable through active video.
// Commands (SPEED / RECENTER / PAUSE / STEP) are accepted only while IDLE.
// Optional feature: define MOTION_BOUNCE_CNT_EN to build the saturating wall-hit counter;
// when it is undefined, bounce_cnt is tied to zero.
module ball_motion_sched #(
    parameter int H_MAX  = 640,
    parameter int V_MAX  = 480,
    parameter int BALL_R = 20,
    parameter int X0     = 320,
    parameter int Y0     = 240,
    parameter int SPD_W  = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_tick,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [7:0] cmd_data,
    output logic [9:0] ball_x,
    output logic [9:0] ball_y,
    output logic       dir_x,
    output logic       dir_y,
    output logic       paused,
    output logic       update_done,
    output logic       overrun,
    output logic [7:0] bounce_cnt
);

    typedef enum logic [1:0] {IDLE, CALC_X, CALC_Y, COMMIT} state_t;
    typedef enum logic [1:0] {OP_SPEED = 2'b00, OP_RECENTER = 2'b01,
                              OP_PAUSE = 2'b10, OP_STEP = 2'b11} op_t;

    localparam logic signed [10:0] LO       = 11'(BALL_R);
    localparam logic signed [10:0] X_HI     = 11'(H_MAX - 1 - BALL_R);
    localparam logic signed [10:0] Y_HI     = 11'(V_MAX - 1 - BALL_R);
    localparam logic [9:0]         X_INIT   = 10'(X0);
    localparam logic [9:0]         Y_INIT   = 10'(Y0);
    localparam logic [SPD_W-1:0]   SPD_INIT = SPD_W'(2);

    state_t             state_q, state_d;
    logic [9:0]         ball_x_q, ball_x_d;
    logic [9:0]         ball_y_q, ball_y_d;
    logic               dir_x_q, dir_x_d;
    logic               dir_y_q, dir_y_d;
    logic [SPD_W-1:0]   sx_q, sx_d;
    logic [SPD_W-1:0]   sy_q, sy_d;
    logic               paused_q, paused_d;
    logic               step_pend_q, step_pend_d;
    logic               update_done_q, update_done_d;
    logic               overrun_q, overrun_d;
    logic signed [10:0] nx_q, nx_d;
    logic signed [10:0] ny_q, ny_d;

    logic               cmd_acc;
    logic signed [10:0] sx_ext, sy_ext, bx_ext, by_ext;
    logic               x_hit_lo, x_hit_hi, y_hit_lo, y_hit_hi;

    assign cmd_ready = (state_q == IDLE);
    assign cmd_acc   = cmd_valid && cmd_ready;

    // 11-bit signed arithmetic keeps a left/top underflow negative instead of wrapping.
    assign sx_ext = {{(11 - SPD_W){1'b0}}, sx_q};
    assign sy_ext = {{(11 - SPD_W){1'b0}}, sy_q};
    assign bx_ext = {1'b0, ball_x_q};
    assign by_ext = {1'b0, ball_y_q};

    // A wall only clamps when the ball is heading toward it.
    assign x_hit_lo = (nx_q <= LO)   && !dir_x_q;
    assign x_hit_hi = (nx_q >= X_HI) &&  dir_x_q;
    assign y_hit_lo = (ny_q <= LO)   && !dir_y_q;
    assign y_hit_hi = (ny_q >= Y_HI) &&  dir_y_q;

    // Next-state, command handling and position datapath.
    always_comb begin
        state_d       = state_q;
        ball_x_d      = ball_x_q;
        ball_y_d      = ball_y_q;
        dir_x_d       = dir_x_q;
        dir_y_d       = dir_y_q;
        sx_d          = sx_q;
        sy_d          = sy_q;
        paused_d      = paused_q;
        step_pend_d   = step_pend_q;
        nx_d          = nx_q;
        ny_d          = ny_q;
        overrun_d     = overrun_q || (frame_tick && (state_q != IDLE));
        update_done_d = (state_q == COMMIT);

        unique case (state_q)
            IDLE: begin
                if (cmd_acc) begin
                    unique case (op_t'(cmd_op))
                        OP_SPEED: begin
                            sx_d = cmd_data[SPD_W-1:0];
                            sy_d = cmd_data[4 +: SPD_W];
                        end
                        OP_RECENTER: begin
                            ball_x_d = X_INIT;
                            ball_y_d = Y_INIT;
                            dir_x_d  = 1'b1;
                            dir_y_d  = 1'b1;
                        end
                        OP_PAUSE: begin
                            paused_d = cmd_data[0];
                            if (!cmd_data[0]) step_pend_d = 1'b0;
                        end
                        OP_STEP: begin
                            if (paused_q) step_pend_d = 1'b1;
                        end
                    endcase
                end
                // The same-edge command is applied first, so its pause/step result gates the tick.
                if (frame_tick && (!paused_d || step_pend_d)) state_d = CALC_X;
            end
            CALC_X: begin
                nx_d    = dir_x_q ? (bx_ext + sx_ext) : (bx_ext - sx_ext);
                state_d = CALC_Y;
            end
            CALC_Y: begin
                ny_d    = dir_y_q ? (by_ext + sy_ext) : (by_ext - sy_ext);
                state_d = COMMIT;
            end
            COMMIT: begin
                if (x_hit_lo) begin
                    ball_x_d = LO[9:0];
                    dir_x_d  = 1'b1;
                end else if (x_hit_hi) begin
                    ball_x_d = X_HI[9:0];
                    dir_x_d  = 1'b0;
                end else begin
                    ball_x_d = nx_q[9:0];
                end
                if (y_hit_lo) begin
                    ball_y_d = LO[9:0];
                    dir_y_d  = 1'b1;
                end else if (y_hit_hi) begin
                    ball_y_d = Y_HI[9:0];
                    dir_y_d  = 1'b0;
                end else begin
                    ball_y_d = ny_q[9:0];
                end
                step_pend_d = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

    // State and committed-output registers; reset also discards any partial nx/ny.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            ball_x_q      <= X_INIT;
            ball_y_q      <= Y_INIT;
            dir_x_q       <= 1'b1;
            dir_y_q       <= 1'b1;
            sx_q          <= SPD_INIT;
            sy_q          <= SPD_INIT;
            paused_q      <= 1'b0;
            step_pend_q   <= 1'b0;
            update_done_q <= 1'b0;
            overrun_q     <= 1'b0;
            nx_q          <= '0;
            ny_q          <= '0;
        end else begin
            state_q       <= state_d;
            ball_x_q      <= ball_x_d;
            ball_y_q      <= ball_y_d;
            dir_x_q       <= dir_x_d;
            dir_y_q       <= dir_y_d;
            sx_q          <= sx_d;
            sy_q          <= sy_d;
            paused_q      <= paused_d;
            step_pend_q   <= step_pend_d;
            update_done_q <= update_done_d;
            overrun_q     <= overrun_d;
            nx_q          <= nx_d;
            ny_q          <= ny_d;
        end
    end

`ifdef MOTION_BOUNCE_CNT_EN
    logic [7:0] bounce_q, bounce_d;
    logic       hit_x, hit_y;
    logic [8:0] bounce_sum;

    // Count wall hits at commit on moving axes only; a corner adds two; saturate at 255.
    always_comb begin
        hit_x      = (state_q == COMMIT) && (x_hit_lo || x_hit_hi) && (sx_q != '0);
        hit_y      = (state_q == COMMIT) && (y_hit_lo || y_hit_hi) && (sy_q != '0);
        bounce_sum = {1'b0, bounce_q} + 9'(hit_x) + 9'(hit_y);
        bounce_d   = bounce_sum[8] ? '1 : bounce_sum[7:0];
    end

    // Bounce counter register; RECENTER leaves it alone, only reset clears it.
    always_ff @(posedge clk) begin
        if (!rst_n) bounce_q <= '0;
        else        bounce_q <= bounce_d;
    end

    assign bounce_cnt = bounce_q;
`else
    assign bounce_cnt = '0;
`endif

    assign ball_x      = ball_x_q;
    assign ball_y      = ball_y_q;
    assign dir_x       = dir_x_q;
    assign dir_y       = dir_y_q;
    assign paused      = paused_q;
    assign update_done = update_done_q;
    assign overrun     = overrun_q;

endmodule

// File: tb/tb_ball_motion_sched.sv
// tb_ball_motion_sched: directed stimulus, a transaction-level motion model checked every
// cycle, and literal checkpoints that pin the model to hand-computed positions.
module tb_ball_motion_sched;

    localparam int H_MAX = 640;
    localparam int V_MAX = 480;
    localparam int R     = 20;
    localparam int X0    = 320;
    localparam int Y0    = 240;
    localparam int XHI   = H_MAX - 1 - R;
    localparam int YHI   = V_MAX - 1 - R;
`ifdef MOTION_BOUNCE_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif
    localparam logic [1:0] SPEED    = 2'b00;
    localparam logic [1:0] RECENTER = 2'b01;
    localparam logic [1:0] PAUSE    = 2'b10;
    localparam logic [1:0] STEP     = 2'b11;

    logic       clk        = 1'b0;
    logic       rst_n      = 1'b0;
    logic       frame_tick = 1'b0;
    logic       cmd_valid  = 1'b0;
    logic [1:0] cmd_op     = 2'b00;
    logic [7:0] cmd_data   = 8'h00;
    logic       cmd_ready;
    logic [9:0] ball_x, ball_y;
    logic       dir_x, dir_y, paused, update_done, overrun;
    logic [7:0] bounce_cnt;

    int checks   = 0;
    int failures = 0;
    int done_cnt = 0;

    always #5 clk = ~clk;

    ball_motion_sched dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .frame_tick  (frame_tick),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_data    (cmd_data),
        .ball_x      (ball_x),
        .ball_y      (ball_y),
        .dir_x       (dir_x),
        .dir_y       (dir_y),
        .paused      (paused),
        .update_done (update_done),
        .overrun     (overrun),
        .bounce_cnt  (bounce_cnt)
    );

    task automatic chk(input string nm, input int act, input int want);
        checks++;
        if (act != want) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, want, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int m_x = X0, m_y = Y0, m_dx = 1, m_dy = 1, m_sx = 2, m_sy = 2;
    int m_paused = 0, m_step = 0, m_cnt = 0, m_ovr = 0, m_done = 0, m_busy = 0;
    int p_x, p_y, p_dx, p_dy, p_cnt, hx, hy;

    function automatic void axis(input int pos, input int dir, input int spd, input int hi,
                                 output int npos, output int ndir, output int hit);
        int n;
        n    = dir ? pos + spd : pos - spd;
        npos = n;
        ndir = dir;
        hit  = 0;
        if (n <= R && dir == 0) begin
            npos = R;  ndir = 1; hit = (spd != 0);
        end else if (n >= hi && dir == 1) begin
            npos = hi; ndir = 0; hit = (spd != 0);
        end
    endfunction

    // Whole update result is computed at the tick and made visible three edges later.
    always @(posedge clk) begin
        m_done = 0;
        if (!rst_n) begin
            m_x = X0; m_y = Y0; m_dx = 1; m_dy = 1; m_sx = 2; m_sy = 2;
            m_paused = 0; m_step = 0; m_cnt = 0; m_ovr = 0; m_busy = 0;
        end else if (m_busy != 0) begin
            if (frame_tick) m_ovr = 1;
            m_busy--;
            if (m_busy == 0) begin
                m_x = p_x; m_y = p_y; m_dx = p_dx; m_dy = p_dy; m_cnt = p_cnt;
                m_step = 0; m_done = 1;
            end
        end else begin
            if (cmd_valid) begin
                case (cmd_op)
                    SPEED:    begin m_sx = cmd_data & 8'h0F; m_sy = cmd_data >> 4; end
                    RECENTER: begin m_x = X0; m_y = Y0; m_dx = 1; m_dy = 1; end
                    PAUSE:    begin m_paused = cmd_data[0]; if (!cmd_data[0]) m_step = 0; end
                    default:  begin if (m_paused != 0) m_step = 1; end
                endcase
            end
            if (frame_tick && (m_paused == 0 || m_step == 1)) begin
                axis(m_x, m_dx, m_sx, XHI, p_x, p_dx, hx);
                axis(m_y, m_dy, m_sy, YHI, p_y, p_dy, hy);
                p_cnt = m_cnt + hx + hy;
                if (p_cnt > 255) p_cnt = 255;
                m_busy = 3;
            end
        end
    end

    // Every-cycle comparison against the model, sampled after the edge has settled.
    always @(posedge clk) begin
        #2;
        chk("cmd_ready",   cmd_ready,   int'(m_busy == 0));
        chk("ball_x",      ball_x,      m_x);
        chk("ball_y",      ball_y,      m_y);
        chk("dir_x",       dir_x,       m_dx);
        chk("dir_y",       dir_y,       m_dy);
        chk("paused",      paused,      m_paused);
        chk("update_done", update_done, m_done);
        chk("overrun",     overrun,     m_ovr);
        chk("bounce_cnt",  bounce_cnt,  CNT_EN ? m_cnt : 0);
        if (update_done === 1'b1) done_cnt++;
    end

    // ---------------- stimulus ----------------
    task automatic do_tick();
        @(negedge clk); frame_tick = 1'b1;
        @(negedge clk); frame_tick = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) do_tick();
    endtask

    task automatic send(input logic [1:0] op, input logic [7:0] d);
        @(negedge clk); cmd_valid = 1'b1; cmd_op = op; cmd_data = d;
        @(negedge clk); cmd_valid = 1'b0;
    endtask

    task automatic send_tick(input logic [1:0] op, input logic [7:0] d);
        @(negedge clk); cmd_valid = 1'b1; cmd_op = op; cmd_data = d; frame_tick = 1'b1;
        @(negedge clk); cmd_valid = 1'b0; frame_tick = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "simulation timed out");
    end

    initial begin
        int d0;
        int waited;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // 1: reset state, then one tick with exact latency
        chk("rst_ball_x", ball_x, 320);
        chk("rst_ball_y", ball_y, 240);
        chk("rst_ready", cmd_ready, 1);
        chk("rst_bounce", bounce_cnt, 0);
        chk("rst_overrun", overrun, 0);
        @(negedge clk); frame_tick = 1'b1;
        @(negedge clk); frame_tick = 1'b0;
        chk("t1_ready_busy", cmd_ready, 0);
        repeat (2) @(negedge clk);
        chk("t1_x_before_commit", ball_x, 320);
        chk("t1_done_before_commit", update_done, 0);
        @(negedge clk);
        chk("t1_x", ball_x, 322);
        chk("t1_y", ball_y, 242);
        chk("t1_done_pulse", update_done, 1);
        chk("t1_dirs", {dir_x, dir_y}, 3);
        @(negedge clk);
        chk("t1_done_once", done_cnt, 1);

        // 2: right wall with sx=5, sy=0
        send(RECENTER, 8'h00);
        send(SPEED, 8'h05);
        ticks(59);
        chk("t2_x_615", ball_x, 615);
        do_tick();
        chk("t2_x_clamp", ball_x, 619);
        chk("t2_dir_x", dir_x, 0);
        chk("t2_y_still", ball_y, 240);
        chk("t2_bounce", bounce_cnt, CNT_EN ? 1 : 0);

        // 3: steer into the top-left corner
        send(SPEED, 8'h0F);
        ticks(39);
        chk("t3_x_34", ball_x, 34);
        send(SPEED, 8'h0B);
        do_tick();
        chk("t3_x_23", ball_x, 23);
        send(SPEED, 8'hF0);
        ticks(15);
        chk("t3_y_clamp", ball_y, 459);
        chk("t3_dir_y", dir_y, 0);
        chk("t3_bounce2", bounce_cnt, CNT_EN ? 2 : 0);
        ticks(29);
        send(SPEED, 8'h10);
        do_tick();
        chk("t3_pre_x", ball_x, 23);
        chk("t3_pre_y", ball_y, 23);
        chk("t3_pre_dirs", {dir_x, dir_y}, 0);
        send(SPEED, 8'h77);
        do_tick();
        chk("t3_corner_x", ball_x, 20);
        chk("t3_corner_y", ball_y, 20);
        chk("t3_corner_dirs", {dir_x, dir_y}, 3);
        chk("t3_bounce4", bounce_cnt, CNT_EN ? 4 : 0);

        // 4: pause / step, plus same-edge command and tick
        send(PAUSE, 8'h01);
        d0 = done_cnt;
        ticks(3);
        chk("t4_paused_x", ball_x, 20);
        chk("t4_paused_nodone", done_cnt, d0);
        send(STEP, 8'h00);
        do_tick();
        chk("t4_step_x", ball_x, 27);
        chk("t4_step_once", done_cnt, d0 + 1);
        do_tick();
        chk("t4_after_step_x", ball_x, 27);
        chk("t4_after_step_nodone", done_cnt, d0 + 1);
        send_tick(STEP, 8'h00);
        chk("t4_step_same_edge", ball_y, 34);
        send_tick(PAUSE, 8'h00);
        chk("t4_unpause_same_edge", ball_x, 41);
        chk("t4_unpaused", paused, 0);
        send_tick(PAUSE, 8'h01);
        chk("t4_pause_same_edge", ball_x, 41);
        chk("t4_paused_again", paused, 1);
        send(PAUSE, 8'h00);
        send_tick(SPEED, 8'h21);
        chk("t4_speed_same_x", ball_x, 42);
        chk("t4_speed_same_y", ball_y, 43);
        send_tick(RECENTER, 8'h00);
        chk("t4_recenter_same_x", ball_x, 321);
        chk("t4_recenter_same_y", ball_y, 242);

        // 5: tick while busy sets sticky overrun; held command waits for IDLE
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        d0 = done_cnt;
        @(negedge clk); frame_tick = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = SPEED; cmd_data = 8'h33;
        chk("t5_ready_low", cmd_ready, 0);
        waited = 0;
        while (!cmd_ready && waited < 20) begin
            @(negedge clk);
            waited++;
            frame_tick = 1'b0;
        end
        frame_tick = 1'b0;
        chk("t5_ready_wait", waited, 3);
        chk("t5_overrun", overrun, 1);
        chk("t5_x_commit", ball_x, 322);
        @(negedge clk); cmd_valid = 1'b0;
        chk("t5_one_update", done_cnt, d0 + 1);
        do_tick();
        chk("t5_new_speed_x", ball_x, 325);
        chk("t5_new_speed_y", ball_y, 245);
        chk("t5_overrun_sticky", overrun, 1);

        // 6: reset during CALC_Y
        @(negedge clk); frame_tick = 1'b1;
        @(negedge clk); frame_tick = 1'b0;
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk);
        chk("t6_x", ball_x, 320);
        chk("t6_y", ball_y, 240);
        chk("t6_dirs", {dir_x, dir_y}, 3);
        chk("t6_paused", paused, 0);
        chk("t6_done", update_done, 0);
        chk("t6_overrun", overrun, 0);
        chk("t6_bounce", bounce_cnt, 0);
        chk("t6_ready", cmd_ready, 1);
        rst_n = 1'b1;
        d0 = done_cnt;
        repeat (6) @(negedge clk);
        chk("t6_no_commit", done_cnt, d0);
        chk("t6_x_held", ball_x, 320);
        do_tick();
        chk("t6_reset_speed_x", ball_x, 322);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ball_motion_sched.md
# ball_motion_sched

Frame-synchronous motion scheduler for the bouncing-ball sprite in the VGA demo. Once per frame, during vertical blanking, it sequences a multi-cycle position and bounce update. Software-style commands over a valid/ready port set speed, recenter, pause, and single-step the motion. The pixel renderer consumes `ball_x`/`ball_y`, which change only at commit and are therefore stable through active video.

## Interface

Parameters:
- `H_MAX`, 640: active width in pixels.
- `V_MAX`, 480: active height in pixels.
- `BALL_R`, 20: ball radius; sets the clamp limits.
- `X0`, 320: reset and recenter x.
- `Y0`, 240: reset and recenter y.
- `SPD_W`, 4: width of each speed field.

Ports:
- `clk` in 1: pixel clock.
- `rst_n` in 1: reset, synchronous, active-low; clock `clk`.
- `frame_tick` in 1: 1-cycle pulse; integrator drives it at hpos==0, vpos==V_MAX (start of vblank).
- `cmd_valid` in 1: command request.
- `cmd_ready` out 1: command acceptance; equals (state==IDLE).
- `cmd_op` in 2: 00 SPEED, 01 RECENTER, 10 PAUSE, 11 STEP.
- `cmd_data` in 8: SPEED uses [3:0]=sx and [7:4]=sy; PAUSE uses [0]=pause.
- `ball_x` out 10: committed ball centre x.
- `ball_y` out 10: committed ball centre y.
- `dir_x` out 1: 1 = moving right.
- `dir_y` out 1: 1 = moving down.
- `paused` out 1: current pause state.
- `update_done` out 1: 1-cycle pulse in the cycle the new position becomes visible.
- `overrun` out 1: sticky; set when `frame_tick` arrives while the FSM is not in IDLE.
- `bounce_cnt` out 8: saturating wall-hit count.

## Operation

FSM states and transitions:
- **IDLE**
  - Go to CALC_X when `frame_tick` is high and either (!paused) or step_pend is set.
  - Otherwise remain in IDLE.
- **CALC_X**
  - nx = {1'b0,ball_x} ± sx, 11-bit signed: + when dir_x=1, − when dir_x=0.
  - Latch nx. Next state: CALC_Y.
- **CALC_Y**
  - ny computed the same way from ball_y, sy and dir_y.
  - Latch ny. Next state: COMMIT.
- **COMMIT** (applies to both axes, with limits lo=BALL_R and hi=H_MAX-1-BALL_R for x, V_MAX-1-BALL_R for y)
  - If n ≤ lo and the ball is moving toward lo: position = lo, direction flips to 1, and it counts as a bounce.
  - If n ≥ hi and the ball is moving toward hi: position = hi, direction flips to 0, and it counts as a bounce.
  - Otherwise: position = n[9:0].
  - A bounce increments `bounce_cnt` only when that axis speed is nonzero.
  - A double bounce (both axes, corner) increments the count by 2. The count saturates at 255.
  - Clear step_pend. Next state: IDLE.

Commands:
- A command is accepted when `cmd_valid` && `cmd_ready`. It takes effect at the accepting edge.
- SPEED: loads sx and sy. Reset values are sx=2, sy=2.
- RECENTER: ball_x=X0, ball_y=Y0, dir_x=1, dir_y=1. `bounce_cnt` is unchanged.
- PAUSE: paused=cmd_data[0]. Unpausing clears step_pend.
- STEP: if paused, sets step_pend. If not paused, it is ignored.

Same-edge command and tick in IDLE:
- Both the command and the tick are accepted.
- The command is applied first. CALC_X/CALC_Y use the updated sx, sy, position and pause state.
- A tick with PAUSE=1 in the same edge does not start an update.
- A tick with STEP in the same edge while paused does start an update.

Other rules:
- A `frame_tick` arriving outside IDLE is dropped and `overrun` is set. `overrun` clears only on reset.
- All arithmetic is 11-bit signed, so no 10-bit wrap-around can occur. Left- and top-wall underflow is caught by the clamp.

## Timing

Update latency:
- Tick sampled at edge E0 (IDLE→CALC_X).
- E1 → CALC_Y; E2 → COMMIT.
- At E3: the outputs `ball_x`, `ball_y`, `dir_x`, `dir_y` and `bounce_cnt` update, and `update_done` goes high for the cycle after E3.
- The FSM is busy for 3 cycles and is back in IDLE after E3.
- `cmd_ready` is low from E0 to E3.
- All outputs are registered; there is no combinational path from an input to an output except `cmd_ready`, which depends on state only.

Reset values, taking effect on the next edge, including mid-update:
- state = IDLE
- `ball_x`=X0, `ball_y`=Y0, `dir_x`=1, `dir_y`=1
- sx=2, sy=2
- `paused`=0, step_pend=0
- `update_done`=0, `overrun`=0, `bounce_cnt`=0
- `cmd_ready`=1 in the first cycle after reset.
- Any partial nx/ny is discarded.

## Configuration

Macro `MOTION_BOUNCE_CNT_EN`:
- **Defined:** the 8-bit saturating bounce counter is implemented as described in Operation.
- **Undefined:** no counter flops are built and `bounce_cnt` is tied to 8'd0. Clamping and direction flips are unaffected.

## Test plan

1. Reset, then one `frame_tick` → after 3 edges `ball_x`=322, `ball_y`=242, `update_done` pulses once, `dir_x`=`dir_y`=1.
2. SPEED sx=5, sy=0 followed by ticks until the right wall → `ball_x` clamps at 619, `dir_x`=0, `bounce_cnt`=1; `ball_y` stays 240 with no y-bounce counted.
3. Drive the ball into the top-left corner with sx=sy=7, moving left/up, from (23,23) → commit gives (20,20), `dir_x`=`dir_y`=1, `bounce_cnt`+2, and no wrap to ~1020.
4. PAUSE=1 followed by 3 ticks → position is unchanged and there is no `update_done`. Then STEP followed by a tick → exactly one update. A further tick → no update.
5. `frame_tick` in the cycle after E0 → `overrun`=1 (sticky), the update completes normally, and `cmd_valid` held during busy is accepted only at E3+.
6. `rst_n` low during CALC_Y → the next cycle shows the full reset values; the interrupted update never commits.
